// File: rtl/id_branch_resolver_if.sv
// Bundle between the fetch/decode pipeline and the ID-stage branch resolver.
// The pipeline side drives the ID operands and reads redirects, predictions and counters.
interface id_branch_resolver_if #(
   parameter int ISA_WIDTH     = 32,
   parameter int COUNTER_WIDTH = 16
);
   logic [ISA_WIDTH-1:0]     if_pc;
   logic                     if_predict_taken;
   logic [ISA_WIDTH-1:0]     if_predict_target;
   logic                     id_valid;
   logic                     id_stall;
   logic [ISA_WIDTH-1:0]     id_pc;
   logic [ISA_WIDTH-1:0]     id_instruction;
   logic [ISA_WIDTH-1:0]     id_reg_1;
   logic [ISA_WIDTH-1:0]     id_sign_extend_result;
   logic                     branch_instruction;
   logic                     j_instruction;
   logic                     jal_instruction;
   logic                     jr_instruction;
   logic                     condition_satisfied;
   logic                     id_predicted_taken;
   logic [ISA_WIDTH-1:0]     id_predicted_target;
   logic                     redirect;
   logic [ISA_WIDTH-1:0]     redirect_pc;
   logic [COUNTER_WIDTH-1:0] branch_count;
   logic [COUNTER_WIDTH-1:0] mispredict_count;

   modport master (
      output if_pc, id_valid, id_stall, id_pc, id_instruction, id_reg_1,
             id_sign_extend_result, branch_instruction, j_instruction,
             jal_instruction, jr_instruction, condition_satisfied,
             id_predicted_taken, id_predicted_target,
      input  if_predict_taken, if_predict_target, redirect, redirect_pc,
             branch_count, mispredict_count
   );

   modport slave (
      input  if_pc, id_valid, id_stall, id_pc, id_instruction, id_reg_1,
             id_sign_extend_result, branch_instruction, j_instruction,
             jal_instruction, jr_instruction, condition_satisfied,
             id_predicted_taken, id_predicted_target,
      output if_predict_taken, if_predict_target, redirect, redirect_pc,
             branch_count, mispredict_count
   );
endinterface

// File: rtl/id_branch_resolver.sv
// ID-stage jump/branch resolver: checks fetch predictions, issues same-cycle redirects,
// trains a direct-mapped 2-bit BHT with targets and keeps saturating branch statistics.
module id_branch_resolver #(
   parameter int ISA_WIDTH     = 32,
   parameter int ADDRES_WIDTH  = 26,
   parameter int BHT_DEPTH     = 16,
   parameter int COUNTER_WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst,
   id_branch_resolver_if.slave bus
);
   localparam int IDX = $clog2(BHT_DEPTH);

   logic                     valid_q  [BHT_DEPTH];
   logic                     valid_d  [BHT_DEPTH];
   logic [1:0]               ctr_q    [BHT_DEPTH];
   logic [1:0]               ctr_d    [BHT_DEPTH];
   logic [ISA_WIDTH-1:0]     target_q [BHT_DEPTH];
   logic [ISA_WIDTH-1:0]     target_d [BHT_DEPTH];
   logic [COUNTER_WIDTH-1:0] branch_count_q;
   logic [COUNTER_WIDTH-1:0] branch_count_d;
   logic [COUNTER_WIDTH-1:0] mispredict_count_q;
   logic [COUNTER_WIDTH-1:0] mispredict_count_d;

   logic                 act_s;
   logic                 taken_s;
   logic                 mispredict_s;
   logic                 bht_upd_s;
   logic                 redirect_s;
   logic [ISA_WIDTH-1:0] redirect_pc_s;
   logic [ISA_WIDTH-1:0] pc4_s;
   logic [ISA_WIDTH-1:0] btgt_s;
   logic [ISA_WIDTH-1:0] jtgt_s;
   logic [IDX-1:0]       rd_idx_s;
   logic [IDX-1:0]       wr_idx_s;
   logic                 unused_s;

   assign act_s    = bus.id_valid & ~bus.id_stall & ~rst;
   assign taken_s  = bus.condition_satisfied;
   assign pc4_s    = bus.id_pc + ISA_WIDTH'(32'd4);
   assign btgt_s   = pc4_s + (bus.id_sign_extend_result << 2);
   assign jtgt_s   = {pc4_s[ISA_WIDTH-1:ADDRES_WIDTH+2], bus.id_instruction[ADDRES_WIDTH-1:0], 2'b00};
   assign rd_idx_s = bus.if_pc[IDX+1:2];
   assign wr_idx_s = bus.id_pc[IDX+1:2];
   assign unused_s = ^{bus.if_pc, bus.id_instruction};

   assign bht_upd_s    = act_s & bus.branch_instruction;
   assign mispredict_s = bht_upd_s & ((taken_s != bus.id_predicted_taken) |
                                      (taken_s & (btgt_s != bus.id_predicted_target)));

   // Redirect selection; the decode flags are one-hot so priority order is irrelevant.
   always_comb begin
      redirect_s    = 1'b0;
      redirect_pc_s = pc4_s;
      if (!act_s) begin
         redirect_s = 1'b0;
      end else if (bus.j_instruction || bus.jal_instruction) begin
         redirect_s    = 1'b1;
         redirect_pc_s = jtgt_s;
      end else if (bus.jr_instruction) begin
         redirect_s    = 1'b1;
         redirect_pc_s = bus.id_reg_1;
      end else if (bus.branch_instruction) begin
         redirect_s    = mispredict_s;
         redirect_pc_s = taken_s ? btgt_s : pc4_s;
      end else begin
         redirect_s    = bus.id_predicted_taken;
         redirect_pc_s = pc4_s;
      end
   end

   // BHT training and saturating statistics.
   always_comb begin
      valid_d            = valid_q;
      ctr_d              = ctr_q;
      target_d           = target_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (bht_upd_s) begin
         valid_d[wr_idx_s] = 1'b1;
         if (taken_s) begin
            ctr_d[wr_idx_s]    = (ctr_q[wr_idx_s] == 2'b11) ? 2'b11 : ctr_q[wr_idx_s] + 2'b01;
            target_d[wr_idx_s] = btgt_s;
         end else begin
            ctr_d[wr_idx_s]    = (ctr_q[wr_idx_s] == 2'b00) ? 2'b00 : ctr_q[wr_idx_s] - 2'b01;
         end
         if (branch_count_q != {COUNTER_WIDTH{1'b1}}) begin
            branch_count_d = branch_count_q + COUNTER_WIDTH'(1);
         end else begin
            branch_count_d = branch_count_q;
         end
      end else begin
         branch_count_d = branch_count_q;
      end
      if (mispredict_s && (mispredict_count_q != {COUNTER_WIDTH{1'b1}})) begin
         mispredict_count_d = mispredict_count_q + COUNTER_WIDTH'(1);
      end else begin
         mispredict_count_d = mispredict_count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            ctr_q[i]    <= 2'b01;
            target_q[i] <= {ISA_WIDTH{1'b0}};
         end
         branch_count_q     <= {COUNTER_WIDTH{1'b0}};
         mispredict_count_q <= {COUNTER_WIDTH{1'b0}};
      end else begin
         valid_q            <= valid_d;
         ctr_q              <= ctr_d;
         target_q           <= target_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign bus.if_predict_taken  = valid_q[rd_idx_s] & ctr_q[rd_idx_s][1];
   assign bus.if_predict_target = target_q[rd_idx_s];
   assign bus.redirect          = redirect_s;
   assign bus.redirect_pc       = redirect_pc_s;
   assign bus.branch_count      = branch_count_q;
   assign bus.mispredict_count  = mispredict_count_q;
endmodule

// File: tb/tb_id_branch_resolver.sv
// Directed-vector bench for id_branch_resolver with hand-computed expectations.
module tb_id_branch_resolver;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   id_branch_resolver_if #(.ISA_WIDTH(32), .COUNTER_WIDTH(4)) bus ();

   id_branch_resolver #(
      .ISA_WIDTH(32), .ADDRES_WIDTH(26), .BHT_DEPTH(16), .COUNTER_WIDTH(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid = 1'b0; bus.id_stall = 1'b0; bus.id_pc = 32'h0;
      bus.id_instruction = 32'h0; bus.id_reg_1 = 32'h0; bus.id_sign_extend_result = 32'h0;
      bus.branch_instruction = 1'b0; bus.j_instruction = 1'b0; bus.jal_instruction = 1'b0;
      bus.jr_instruction = 1'b0; bus.condition_satisfied = 1'b0;
      bus.id_predicted_taken = 1'b0; bus.id_predicted_target = 32'h0;
   endtask

   task automatic branch(input logic [31:0] pc, input logic [31:0] imm, input logic cond,
                         input logic ptaken, input logic [31:0] ptgt);
      idle();
      bus.id_valid = 1'b1; bus.branch_instruction = 1'b1; bus.id_pc = pc;
      bus.id_sign_extend_result = imm; bus.condition_satisfied = cond;
      bus.id_predicted_taken = ptaken; bus.id_predicted_target = ptgt;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      bus.if_pc = pc;
      #1;
      chk({tag, "_ptaken"}, {31'd0, bus.if_predict_taken}, {31'd0, tk});
      chk({tag, "_ptgt"}, bus.if_predict_target, tgt);
   endtask

   task automatic counts(input string tag, input logic [3:0] b, input logic [3:0] m);
      chk({tag, "_bcnt"}, {28'd0, bus.branch_count}, {28'd0, b});
      chk({tag, "_mcnt"}, {28'd0, bus.mispredict_count}, {28'd0, m});
   endtask

   task automatic redir(input string tag, input logic r, input logic [31:0] pc);
      #1;
      chk({tag, "_redir"}, {31'd0, bus.redirect}, {31'd0, r});
      if (r) chk({tag, "_rpc"}, bus.redirect_pc, pc);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle();
      bus.if_pc = 32'h0;
      rst = 1'b1;
      // a jump presented under reset must not redirect
      bus.id_valid = 1'b1; bus.j_instruction = 1'b1;
      redir("rst_j", 1'b0, 32'h0);
      step(); step();
      rst = 1'b0;
      idle();
      look("rst", 32'h40, 1'b0, 32'h0);
      counts("rst", 4'd0, 4'd0);

      // first taken branch, predicted not taken
      branch(32'h40, 32'd3, 1'b1, 1'b0, 32'h0);
      redir("br1", 1'b1, 32'h50);
      look("br1_rbw", 32'h40, 1'b0, 32'h0);
      step(); idle();
      counts("br1", 4'd1, 4'd1);
      look("br1_after", 32'h40, 1'b1, 32'h50);

      branch(32'h40, 32'd3, 1'b1, 1'b1, 32'h50);
      redir("br2", 1'b0, 32'h0);
      step(); idle();
      counts("br2", 4'd2, 4'd1);
      look("br2_after", 32'h40, 1'b1, 32'h50);

      // ctr 3->2 keeps predicting taken, 2->1 stops
      branch(32'h40, 32'd3, 1'b0, 1'b1, 32'h50);
      redir("br3", 1'b1, 32'h44);
      step(); idle();
      counts("br3", 4'd3, 4'd2);
      look("br3_after", 32'h40, 1'b1, 32'h50);
      branch(32'h40, 32'd3, 1'b0, 1'b1, 32'h50);
      redir("br4", 1'b1, 32'h44);
      step(); idle();
      look("br4_after", 32'h40, 1'b0, 32'h50);

      branch(32'h88, 32'd1, 1'b1, 1'b1, 32'h99);
      redir("br_tgt", 1'b1, 32'h90);
      step(); idle();
      counts("br_tgt", 4'd5, 4'd4);
      look("br_tgt_after", 32'h88, 1'b1, 32'h90);

      branch(32'h40, 32'd3, 1'b0, 1'b0, 32'h0);
      redir("br_nt", 1'b0, 32'h0);
      step(); idle();
      counts("br_nt", 4'd6, 4'd4);

      // jumps redirect even when predicted and never touch the BHT
      bus.id_valid = 1'b1; bus.j_instruction = 1'b1; bus.id_pc = 32'h0040_0010;
      bus.id_instruction = 32'h0800_0100; bus.id_predicted_taken = 1'b1;
      bus.id_predicted_target = 32'h0000_0400;
      redir("j", 1'b1, 32'h0000_0400);
      step(); idle();
      look("j_after", 32'h0040_0010, 1'b0, 32'h0);
      bus.id_valid = 1'b1; bus.jal_instruction = 1'b1; bus.id_pc = 32'h1000_0000;
      bus.id_instruction = 32'h0C00_0008;
      redir("jal", 1'b1, 32'h1000_0020);
      step(); idle();
      bus.id_valid = 1'b1; bus.jr_instruction = 1'b1; bus.id_pc = 32'h20;
      bus.id_reg_1 = 32'h1234;
      redir("jr", 1'b1, 32'h1234);
      step(); idle();
      look("jr_after", 32'h20, 1'b0, 32'h0);
      counts("jumps", 4'd6, 4'd4);

      bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_predicted_taken = 1'b1;
      redir("alias", 1'b1, 32'h104);
      step();
      branch(32'h30, 32'd0, 1'b1, 1'b0, 32'h0);
      bus.id_valid = 1'b0;
      redir("bubble", 1'b0, 32'h0);
      step();
      counts("bubble", 4'd6, 4'd4);

      // stalled branch resolves once, in the release cycle
      branch(32'h30, 32'd0, 1'b1, 1'b0, 32'h0);
      bus.id_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         redir("stall", 1'b0, 32'h0);
         step();
      end
      counts("stall", 4'd6, 4'd4);
      bus.id_stall = 1'b0;
      redir("release", 1'b1, 32'h34);
      step(); idle();
      counts("release", 4'd7, 4'd5);

      for (int i = 0; i < 21; i++) begin
         branch(32'h30, 32'd0, 1'b1, 1'b0, 32'h0);
         step();
      end
      counts("sat", 4'd15, 4'd15);

      branch(32'h30, 32'd0, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      redir("rst_mid", 1'b0, 32'h0);
      step();
      rst = 1'b0; idle();
      counts("rst_mid", 4'd0, 4'd0);
      look("rst_mid_30", 32'h30, 1'b0, 32'h0);
      look("rst_mid_88", 32'h88, 1'b0, 32'h0);
      // ctr must restart at 01: one taken branch makes it predict taken
      branch(32'h88, 32'd1, 1'b1, 1'b0, 32'h0);
      step(); idle();
      look("post_rst", 32'h88, 1'b1, 32'h90);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
